exec_controller: RTL and testbench
==================================

Name: exec_controller

Overview:
- Sequences execution of the `mips` core by driving a core clock-enable.
- Provides run, halt, single/multi-step and PC breakpoint control, plus an enabled-cycle counter.
- Sits between the board buttons/switches (via the debouncer) and the core's clock enable in `system` and `system_debug`.
- Gives the debug display a stable, controllable core.

Parameters:
- STEP_CYCLES, 1: number of enabled cycles issued per step request (1..255).
- COUNT_W, 32: width of cycle_count.
- RESET_RUN, 0: state after reset; 0 = HALT, 1 = RUN.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- run_req  input  1  level request; rising edge starts free-run.
- step_req  input  1  level request; rising edge issues STEP_CYCLES enabled cycles.
- halt_req  input  1  level request; rising edge stops the core.
- bp_valid  input  1  breakpoint armed.
- bp_addr  input  32  breakpoint PC (byte address).
- pc  input  32  current core PC.
- cnt_clr  input  1  synchronous clear of cycle_count.
- cpu_en  output  1  core clock enable; the core advances only on cycles where it is 1.
- state  output  2  0 = HALT, 1 = RUN, 2 = STEP, 3 = BREAK.
- halted  output  1  1 in HALT or BREAK.
- cycle_count  output  COUNT_W  number of cycles with cpu_en = 1.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = HALT (RUN if RESET_RUN = 1).
  - Edge-detect registers = 0.
  - Step counter = 0; resume mask = 0; cycle_count = 0.
  - cpu_en = RESET_RUN; halted = !RESET_RUN.
- Reset asserted mid-step or mid-run aborts immediately with no pending step.
- Edge detect:
  - Each request is registered once.
  - The event is req & !req_q; a held level produces exactly one event.
  - Simultaneous events resolve with priority halt > step > run.
- bp_hit (combinational) = bp_valid & (pc == bp_addr) & !resume_mask.
- cpu_en (combinational from registered state) = (state == RUN & !bp_hit) | (state == STEP).
- The instruction at a breakpoint PC is not executed before BREAK is entered.
- HALT:
  - step event → STEP, with step counter loaded to STEP_CYCLES.
  - run event → RUN.
  - halt event: no change.
- RUN:
  - halt event → HALT; cpu_en stays 1 on the event cycle, so exactly one more instruction executes.
  - Otherwise bp_hit → BREAK.
  - step event in RUN → STEP, loaded as above.
- STEP:
  - Step counter decrements on each cycle in STEP.
  - When counter == 1 → HALT next cycle; exactly STEP_CYCLES enabled cycles total.
  - halt event → HALT immediately after the current cycle.
  - Breakpoints are ignored in STEP; run and step events are ignored.
- BREAK: cpu_en = 0.
  - run event → RUN with resume_mask set.
  - step event → STEP with resume_mask set.
  - halt event → HALT.
- resume_mask:
  - Clears on the first cycle pc != bp_addr, or on a bp_addr change.
  - Lets the core leave a breakpoint without re-triggering on it.
- cycle_count:
  - Increments on cycles with cpu_en = 1.
  - Saturates at all-ones and never wraps.
  - cnt_clr has priority over increment; count = 0 next cycle.
- halted and state are registered; both reflect the state register.

Optional Feature:
- Macro: CTRL_BREAKPOINT_EN.
- Defined: breakpoint logic exactly as above.
- Undefined:
  - bp_valid and bp_addr are ignored; bp_hit is constant 0.
  - BREAK is unreachable and resume_mask is removed.
  - state never reads 3.

Test Plan:
- Reset low with RESET_RUN = 0, then release → state = 0, cpu_en = 0, halted = 1, cycle_count = 0.
- Pulse step_req, held 5 cycles, STEP_CYCLES = 1 → exactly 1 cycle with cpu_en = 1; state 2 → 0; cycle_count = 1.
- Run_req edge, then halt_req edge 10 cycles later → cpu_en high 11 cycles including the halt event cycle; cycle_count = 11; state = 0.
- CTRL_BREAKPOINT_EN defined, bp_addr = 0x0000_0010, bp_valid = 1, run from pc = 0 advancing 4 per enabled cycle:
  - cpu_en drops in the same cycle pc = 0x10; state = 3.
  - A run edge resumes; pc advances to 0x14 with no re-break.
- Run_req and halt_req rising in the same cycle from HALT → state stays 0, cpu_en = 0.
- COUNT_W = 4, free-run 20 cycles → cycle_count saturates at 0xF; assert cnt_clr with cpu_en = 1 → 0 next cycle.

Source files
------------

// File: rtl/exec_controller.sv
// Execution controller: run / halt / multi-step sequencing of the core clock enable plus an enabled-cycle counter.
// PC breakpoint support (BREAK state, resume mask) is compiled in only when CTRL_BREAKPOINT_EN is defined.
module exec_controller #(
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned COUNT_W     = 32,
    parameter bit          RESET_RUN   = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run_req,
    input  logic               step_req,
    input  logic               halt_req,
    input  logic               bp_valid,
    input  logic [31:0]        bp_addr,
    input  logic [31:0]        pc,
    input  logic               cnt_clr,
    output logic               cpu_en,
    output logic [1:0]         state,
    output logic               halted,
    output logic [COUNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    localparam state_t     RESET_STATE = RESET_RUN ? S_RUN : S_HALT;
    localparam logic [7:0] STEP_LOAD   = 8'(STEP_CYCLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_run_q;
    logic               r_step_q;
    logic               r_halt_q;
    logic [7:0]         r_step_cnt;
    logic [7:0]         w_step_cnt_nxt;
    logic [COUNT_W-1:0] r_cycle_count;
    logic               w_run_ev;
    logic               w_step_ev;
    logic               w_halt_ev;
    logic               w_bp_hit;
    logic               w_resume_set;

    // A held request level yields exactly one event on its first cycle.
    assign w_run_ev  = run_req  & ~r_run_q;
    assign w_step_ev = step_req & ~r_step_q;
    assign w_halt_ev = halt_req & ~r_halt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run_q  <= 1'b0;
            r_step_q <= 1'b0;
            r_halt_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_run_q  <= run_req;
            r_step_q <= step_req;
            r_halt_q <= halt_req;
        end
    end

`ifdef CTRL_BREAKPOINT_EN
    logic        r_resume_mask;
    logic [31:0] r_bp_addr_q;

    assign w_bp_hit = bp_valid & (pc == bp_addr) & ~r_resume_mask;

    // The mask lets the core leave a breakpoint PC once; it drops as soon as the PC moves or the target changes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_resume_mask <= 1'b0;
            r_bp_addr_q   <= '0;
        end else begin
            r_bp_addr_q <= bp_addr;
            if (w_resume_set) begin
                r_resume_mask <= 1'b1;
            end else if ((pc != bp_addr) || (bp_addr != r_bp_addr_q)) begin
                r_resume_mask <= 1'b0;
            end
        end
    end
`else
    wire w_unused_bp = &{1'b0, bp_valid, bp_addr, pc, w_resume_set};

    assign w_bp_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_nxt    = r_state;
        w_step_cnt_nxt = r_step_cnt;
        w_resume_set   = 1'b0;
        case (r_state)
            S_HALT: begin
                if (!w_halt_ev) begin
                    if (w_step_ev) begin
                        w_state_nxt    = S_STEP;
                        w_step_cnt_nxt = STEP_LOAD;
                    end else if (w_run_ev) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_halt_ev) begin
                    w_state_nxt = S_HALT;
                end else if (w_bp_hit) begin
                    w_state_nxt = S_BREAK;
                end else if (w_step_ev) begin
                    w_state_nxt    = S_STEP;
                    w_step_cnt_nxt = STEP_LOAD;
                end
            end
            S_STEP: begin
                w_step_cnt_nxt = r_step_cnt - 8'd1;
                if (w_halt_ev || (r_step_cnt == 8'd1)) begin
                    w_state_nxt = S_HALT;
                end
            end
            default: begin
                if (w_halt_ev) begin
                    w_state_nxt = S_HALT;
                end else if (w_step_ev) begin
                    w_state_nxt    = S_STEP;
                    w_step_cnt_nxt = STEP_LOAD;
                    w_resume_set   = 1'b1;
                end else if (w_run_ev) begin
                    w_state_nxt  = S_RUN;
                    w_resume_set = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= RESET_STATE;
            r_step_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_cnt <= w_step_cnt_nxt;
        end
    end

    // The breakpoint instruction must not execute, so a hit gates the enable in the same cycle.
    assign cpu_en = ((r_state == S_RUN) & ~w_bp_hit) | (r_state == S_STEP);
    assign state  = r_state;
    assign halted = (r_state == S_HALT) | (r_state == S_BREAK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle_count <= '0;
        end else if (cnt_clr) begin
            r_cycle_count <= '0;
        end else if (cpu_en && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller: directed scenarios plus a randomized run against a behavioural model.
// Two instances share stimulus: A uses defaults, B uses STEP_CYCLES = 3 and COUNT_W = 4.
module tb_exec_controller;

`ifdef CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    localparam int STEPN [2] = '{1, 3};
    localparam longint CMAX [2] = '{64'hFFFF_FFFF, 64'hF};

    logic        clock = 1'b0;
    logic        reset;
    logic        run_req, step_req, halt_req, bp_valid, cnt_clr;
    logic [31:0] bp_addr, pc;

    logic        cpu_en_a, halted_a, cpu_en_b, halted_b;
    logic [1:0]  state_a, state_b;
    logic [31:0] count_a;
    logic [3:0]  count_b;

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt_a, en_cnt_b;
    bit saw_step_a, follow_pc;

    // Behavioural model state (mode: 0 halt, 1 run, 2 step, 3 break).
    int          m_mode [2];
    int          m_steps[2];
    bit          m_mask [2];
    longint      m_count[2];
    bit          m_prev_run, m_prev_step, m_prev_halt;
    logic [31:0] m_prev_addr;

    always #5 clock = ~clock;

    exec_controller u_dut_a (
        .clock(clock), .reset(reset), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
        .bp_valid(bp_valid), .bp_addr(bp_addr), .pc(pc), .cnt_clr(cnt_clr),
        .cpu_en(cpu_en_a), .state(state_a), .halted(halted_a), .cycle_count(count_a)
    );

    exec_controller #(.STEP_CYCLES(3), .COUNT_W(4)) u_dut_b (
        .clock(clock), .reset(reset), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
        .bp_valid(bp_valid), .bp_addr(bp_addr), .pc(pc), .cnt_clr(cnt_clr),
        .cpu_en(cpu_en_b), .state(state_b), .halted(halted_b), .cycle_count(count_b)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One clock cycle: settle, sample enables, cross the edge, then let the emulated core advance its PC.
    task automatic tick();
        bit en;
        #2;
        en = cpu_en_a;
        en_cnt_a += int'(cpu_en_a);
        en_cnt_b += int'(cpu_en_b);
        if (state_a == 2'd2) saw_step_a = 1'b1;
        @(posedge clock);
        #1;
        if (follow_pc && en) pc += 32'd4;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; cnt_clr = 1'b0;
        bp_valid = 1'b0; bp_addr = '0; pc = '0; follow_pc = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        en_cnt_a = 0; en_cnt_b = 0; saw_step_a = 1'b0;
    endtask

    function automatic bit exp_hit(int k);
        return BP_EN && bp_valid && (pc == bp_addr) && !m_mask[k];
    endfunction

    function automatic bit exp_en(int k);
        return ((m_mode[k] == 1) && !exp_hit(k)) || (m_mode[k] == 2);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_steps[k] = 0; m_mask[k] = 1'b0; m_count[k] = 0;
        end
        m_prev_run = 1'b0; m_prev_step = 1'b0; m_prev_halt = 1'b0; m_prev_addr = '0;
    endtask

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_advance();
        bit ev_r, ev_s, ev_h;
        ev_r = run_req && !m_prev_run;
        ev_s = step_req && !m_prev_step;
        ev_h = halt_req && !m_prev_halt;
        for (int k = 0; k < 2; k++) begin
            bit hit, en, set_mask;
            int nmode;
            hit = exp_hit(k);
            en = exp_en(k);
            nmode = m_mode[k];
            set_mask = 1'b0;
            case (m_mode[k])
                0: if (!ev_h) begin
                       if (ev_s) begin nmode = 2; m_steps[k] = STEPN[k]; end
                       else if (ev_r) nmode = 1;
                   end
                1: if (ev_h) nmode = 0;
                   else if (hit) nmode = 3;
                   else if (ev_s) begin nmode = 2; m_steps[k] = STEPN[k]; end
                2: begin
                       if (ev_h || m_steps[k] == 1) nmode = 0;
                       m_steps[k] = m_steps[k] - 1;
                   end
                default: if (ev_h) nmode = 0;
                   else if (ev_s) begin nmode = 2; m_steps[k] = STEPN[k]; set_mask = 1'b1; end
                   else if (ev_r) begin nmode = 1; set_mask = 1'b1; end
            endcase
            if (set_mask) m_mask[k] = 1'b1;
            else if ((pc != bp_addr) || (bp_addr != m_prev_addr)) m_mask[k] = 1'b0;
            if (cnt_clr) m_count[k] = 0;
            else if (en && m_count[k] < CMAX[k]) m_count[k] = m_count[k] + 1;
            m_mode[k] = nmode;
        end
        m_prev_run = run_req; m_prev_step = step_req; m_prev_halt = halt_req; m_prev_addr = bp_addr;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        n_tests++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_a); end
        n_tests++; if (cpu_en_a !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en_a); end
        n_tests++; if (halted_a !== 1'b1) begin n_fail++; $display("FAIL reset_halted: got %b want 1", halted_a); end
        n_tests++; if (count_a !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_a); end
        n_tests++; if (state_b !== 2'd0 || cpu_en_b !== 1'b0 || count_b !== 4'd0) begin
            n_fail++; $display("FAIL reset_b: state %0d en %b count %0d want 0 0 0", state_b, cpu_en_b, count_b);
        end
    endtask

    task automatic test_step();
        do_reset();
        step_req = 1'b1;
        repeat (5) tick();
        step_req = 1'b0;
        repeat (5) tick();
        n_tests++; if (en_cnt_a != 1) begin n_fail++; $display("FAIL step_enables_a: got %0d want 1", en_cnt_a); end
        n_tests++; if (!saw_step_a) begin n_fail++; $display("FAIL step_state_seen: got 0 want 1"); end
        n_tests++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL step_end_state: got %0d want 0", state_a); end
        n_tests++; if (count_a !== 32'd1) begin n_fail++; $display("FAIL step_count_a: got %0d want 1", count_a); end
        n_tests++; if (en_cnt_b != 3) begin n_fail++; $display("FAIL step_enables_b: got %0d want 3", en_cnt_b); end
        n_tests++; if (count_b !== 4'd3) begin n_fail++; $display("FAIL step_count_b: got %0d want 3", count_b); end
    endtask

    task automatic test_run_halt();
        do_reset();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (10) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        repeat (3) tick();
        n_tests++; if (en_cnt_a != 11) begin n_fail++; $display("FAIL run_halt_enables: got %0d want 11", en_cnt_a); end
        n_tests++; if (count_a !== 32'd11) begin n_fail++; $display("FAIL run_halt_count: got %0d want 11", count_a); end
        n_tests++; if (state_a !== 2'd0 || halted_a !== 1'b1) begin
            n_fail++; $display("FAIL run_halt_state: got %0d/%b want 0/1", state_a, halted_a);
        end
        n_tests++; if (count_b !== 4'd11) begin n_fail++; $display("FAIL run_halt_count_b: got %0d want 11", count_b); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        run_req = 1'b1; halt_req = 1'b1;
        tick();
        run_req = 1'b0; halt_req = 1'b0;
        repeat (3) tick();
        n_tests++; if (en_cnt_a != 0 || state_a !== 2'd0) begin
            n_fail++; $display("FAIL run_halt_same_cycle: enables %0d state %0d want 0 0", en_cnt_a, state_a);
        end
        run_req = 1'b1; step_req = 1'b1;
        tick();
        run_req = 1'b0; step_req = 1'b0;
        repeat (3) tick();
        n_tests++; if (en_cnt_a != 1 || state_a !== 2'd0) begin
            n_fail++; $display("FAIL step_over_run: enables %0d state %0d want 1 0", en_cnt_a, state_a);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (20) tick();
        n_tests++; if (count_b !== 4'hF) begin n_fail++; $display("FAIL saturate_b: got %0h want f", count_b); end
        n_tests++; if (count_a !== 32'd20) begin n_fail++; $display("FAIL free_run_count_a: got %0d want 20", count_a); end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_tests++; if (count_b !== 4'd0 || count_a !== 32'd0) begin
            n_fail++; $display("FAIL cnt_clr: got %0d/%0d want 0/0", count_a, count_b);
        end
        tick();
        n_tests++; if (count_a !== 32'd1) begin n_fail++; $display("FAIL count_after_clr: got %0d want 1", count_a); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        step_req = 1'b1;
        tick();
        tick();
        #1;
        n_tests++; if (state_b !== 2'd2) begin n_fail++; $display("FAIL abort_pre_step: got %0d want 2", state_b); end
        reset = 1'b0;
        #1;
        n_tests++; if (state_b !== 2'd0 || cpu_en_b !== 1'b0 || halted_b !== 1'b1) begin
            n_fail++; $display("FAIL abort_async: state %0d en %b halted %b want 0 0 1", state_b, cpu_en_b, halted_b);
        end
        step_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        en_cnt_b = 0;
        repeat (5) tick();
        n_tests++; if (en_cnt_b != 0) begin n_fail++; $display("FAIL abort_no_pending: got %0d want 0", en_cnt_b); end
    endtask

    task automatic test_breakpoint();
        do_reset();
        bp_addr = 32'h10; bp_valid = 1'b1; follow_pc = 1'b1;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
`ifdef CTRL_BREAKPOINT_EN
        for (int i = 0; i < 20 && pc != 32'h10; i++) tick();
        #1;
        n_tests++; if (pc !== 32'h10 || cpu_en_a !== 1'b0) begin
            n_fail++; $display("FAIL bp_gate: pc %0h en %b want 10 0", pc, cpu_en_a);
        end
        tick();
        n_tests++; if (state_a !== 2'd3 || halted_a !== 1'b1 || pc !== 32'h10) begin
            n_fail++; $display("FAIL bp_break: state %0d halted %b pc %0h want 3 1 10", state_a, halted_a, pc);
        end
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tick();
        n_tests++; if (pc !== 32'h14 || state_a !== 2'd1) begin
            n_fail++; $display("FAIL bp_resume: pc %0h state %0d want 14 1", pc, state_a);
        end
        tick();
        n_tests++; if (pc !== 32'h18 || state_a !== 2'd1) begin
            n_fail++; $display("FAIL bp_no_rebreak: pc %0h state %0d want 18 1", pc, state_a);
        end
`else
        repeat (8) tick();
        n_tests++; if (pc !== 32'h20 || state_a !== 2'd1) begin
            n_fail++; $display("FAIL bp_ignored: pc %0h state %0d want 20 1", pc, state_a);
        end
`endif
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
    endtask

    task automatic test_random();
        bit ea, eb;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 5) == 0)  run_req  = ~run_req;
            if ($urandom_range(0, 7) == 0)  step_req = ~step_req;
            if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
            if ($urandom_range(0, 9) == 0)  bp_valid = ~bp_valid;
            if ($urandom_range(0, 7) == 0)  bp_addr  = pc + 32'(4 * $urandom_range(0, 3));
            cnt_clr = ($urandom_range(0, 15) == 0);
            #2;
            ea = exp_en(0);
            eb = exp_en(1);
            n_tests++;
            if (cpu_en_a !== ea || state_a !== 2'(m_mode[0]) || halted_a !== (m_mode[0] == 0 || m_mode[0] == 3)
                || count_a !== m_count[0][31:0]) begin
                n_fail++;
                $display("FAIL random_a cyc %0d: en %b state %0d count %0d want %b %0d %0d",
                         cyc, cpu_en_a, state_a, count_a, ea, m_mode[0], m_count[0]);
            end
            n_tests++;
            if (cpu_en_b !== eb || state_b !== 2'(m_mode[1]) || halted_b !== (m_mode[1] == 0 || m_mode[1] == 3)
                || count_b !== m_count[1][3:0]) begin
                n_fail++;
                $display("FAIL random_b cyc %0d: en %b state %0d count %0d want %b %0d %0d",
                         cyc, cpu_en_b, state_b, count_b, eb, m_mode[1], m_count[1]);
            end
            model_advance();
            @(posedge clock);
            #1;
            if (ea) pc += 32'd4;
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_halt();
        test_simultaneous();
        test_saturate();
        test_reset_abort();
        test_breakpoint();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
